// File: rtl/sum_accumulator.sv
// Block accumulator: sums a stream of unsigned samples and emits one result
// word (total, count, overflow) per block over a valid/ready handshake.
module sum_accumulator #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 16,
   parameter int BLOCK_LEN = 4,
   parameter bit SATURATE  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [7:0]        out_count,
   output logic              out_sat,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [7:0]       BLOCK_LEN_C = 8'(BLOCK_LEN);
   localparam logic [ACC_W-1:0] ACC_MAX     = {ACC_W{1'b1}};

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;
   logic [7:0]         out_count_q, out_count_d;
   logic               out_sat_q, out_sat_d;
   logic               out_valid_q, out_valid_d;

   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   acc_n;
   logic [7:0]         cnt_n;
   logic               sat_n;
   logic               xfer;
   logic               close_blk;

   // Ready depends only on registered state and the enable pin.
   assign in_ready  = en && (state_q == ST_ACC);
   assign xfer      = in_valid && in_ready;

   // One extra bit on the sum exposes the carry used as the overflow flag.
   assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
   assign cnt_n     = cnt_q + 8'd1;
   assign close_blk = (cnt_n == BLOCK_LEN_C) || in_last;

   always_comb begin
      acc_n = sum[ACC_W-1:0];
      sat_n = sat_q;
      if (sum[ACC_W]) begin
         sat_n = 1'b1;
         if (SATURATE) begin
            acc_n = ACC_MAX;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_ACC: begin
            if (xfer) begin
               if (close_blk) begin
                  out_data_d  = acc_n;
                  out_count_d = cnt_n;
                  out_sat_d   = sat_n;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  sat_d       = 1'b0;
                  state_d     = ST_HOLD;
               end else begin
                  acc_d = acc_n;
                  cnt_d = cnt_n;
                  sat_d = sat_n;
               end
            end
         end
         ST_HOLD: begin
            // Result fields stay frozen until the consumer takes them.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_sat   = out_sat_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus random
// traffic compared against a block-level sum model.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        rst, en, in_valid, in_last, out_ready;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_data;
   logic [7:0]  out_count;

   sum_accumulator dut (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
      .out_count(out_count), .out_sat(out_sat), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // Narrow-accumulator instances (ACC_W=9, BLOCK_LEN=3), saturating and wrapping
   logic        s_rst, s_in_valid, s_out_ready;
   logic [7:0]  s_in_data;
   logic        s1_in_ready, s1_out_valid, s1_out_sat;
   logic [8:0]  s1_out_data;
   logic [7:0]  s1_out_count;
   logic        s0_in_ready, s0_out_valid, s0_out_sat;
   logic [8:0]  s0_out_data;
   logic [7:0]  s0_out_count;

   sum_accumulator #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(3), .SATURATE(1'b1)) dut_s1 (
      .clk(clk), .rst(s_rst), .en(1'b1), .in_data(s_in_data), .in_valid(s_in_valid),
      .in_last(1'b0), .in_ready(s1_in_ready), .out_data(s1_out_data),
      .out_count(s1_out_count), .out_sat(s1_out_sat), .out_valid(s1_out_valid),
      .out_ready(s_out_ready)
   );

   sum_accumulator #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(3), .SATURATE(1'b0)) dut_s0 (
      .clk(clk), .rst(s_rst), .en(1'b1), .in_data(s_in_data), .in_valid(s_in_valid),
      .in_last(1'b0), .in_ready(s0_in_ready), .out_data(s0_out_data),
      .out_count(s0_out_count), .out_sat(s0_out_sat), .out_valid(s0_out_valid),
      .out_ready(s_out_ready)
   );

   int checks_cnt = 0;
   int errors_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Block result from the plain arithmetic total of the block's samples.
   function automatic int blk_data(input int total, input int acc_w, input bit satur);
      int lim;
      lim = 1 << acc_w;
      if (total < lim) return total;
      return satur ? lim - 1 : total % lim;
   endfunction

   // Model of the default instance
   int m_q[$];
   bit m_hold;
   int m_data, m_count;
   bit m_sat;

   task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                        input bit e, input bit r, input bit rs);
      int total;
      rst = rs; en = e; in_valid = v; in_data = d; in_last = l; out_ready = r;
      @(negedge clk);
      chk("in_ready", in_ready, e && !m_hold);
      chk("out_valid", out_valid, m_hold);
      if (m_hold) begin
         chk("out_data", out_data, m_data);
         chk("out_count", out_count, m_count);
         chk("out_sat", out_sat, m_sat);
      end
      @(posedge clk);
      if (rs) begin
         m_q.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (r) m_hold = 1'b0;
      end else if (e && v) begin
         m_q.push_back(int'(d));
         if (m_q.size() == 4 || l) begin
            total = 0;
            foreach (m_q[i]) total += m_q[i];
            m_data  = blk_data(total, 16, 1'b1);
            m_sat   = (total >= 65536);
            m_count = m_q.size();
            m_hold  = 1'b1;
            $display("block: count=%0d total=%0d expect data=%0d sat=%0d",
                     m_count, total, m_data, m_sat);
            m_q.delete();
         end
      end
      #1;
   endtask

   initial begin
      int vals[3];
      int total;
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
      m_hold = 1'b0; m_data = 0; m_count = 0; m_sat = 1'b0;

      // Narrow instances: first block 255,255,255, then random blocks
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int b = 0; b < 16; b++) begin
         for (int k = 0; k < 3; k++) vals[k] = (b == 0) ? 255 : int'($urandom_range(0, 255));
         total = vals[0] + vals[1] + vals[2];
         for (int k = 0; k < 3; k++) begin
            s_in_valid = 1'b1; s_in_data = 8'(vals[k]); s_out_ready = 1'($urandom % 2);
            @(negedge clk);
            chk("s1_in_ready", s1_in_ready, 1);
            chk("s0_in_ready", s0_in_ready, 1);
            @(posedge clk); #1;
         end
         s_in_valid = 1'b0; s_out_ready = 1'b1;
         @(negedge clk);
         if (b == 0) begin
            chk("s1_first_data", s1_out_data, 511);
            chk("s0_first_data", s0_out_data, 253);
         end
         chk("s1_valid", s1_out_valid, 1);
         chk("s1_ready_hold", s1_in_ready, 0);
         chk("s1_data", s1_out_data, blk_data(total, 9, 1'b1));
         chk("s1_count", s1_out_count, 3);
         chk("s1_sat", s1_out_sat, total >= 512);
         chk("s0_valid", s0_out_valid, 1);
         chk("s0_data", s0_out_data, blk_data(total, 9, 1'b0));
         chk("s0_count", s0_out_count, 3);
         chk("s0_sat", s0_out_sat, total >= 512);
         $display("narrow block %0d: total=%0d sat_out=%0d wrap_out=%0d", b, total,
                  s1_out_data, s0_out_data);
         @(posedge clk); #1;
      end

      // Default instance: reset state
      cycle(0, 8'd0, 0, 1, 1, 1);
      cycle(0, 8'd0, 0, 1, 1, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // 10,20,30,40 back-to-back
      cycle(1, 8'd10, 0, 1, 1, 0);
      cycle(1, 8'd20, 0, 1, 1, 0);
      cycle(1, 8'd30, 0, 1, 1, 0);
      cycle(1, 8'd40, 0, 1, 1, 0);
      chk("t2_model_data", m_data, 100);
      cycle(0, 8'd0, 0, 1, 1, 0);
      cycle(0, 8'd0, 0, 1, 1, 0);

      // Early close with in_last, then a fresh block
      cycle(1, 8'd5, 0, 1, 1, 0);
      cycle(1, 8'd7, 1, 1, 1, 0);
      chk("t3_model_data", m_data, 12);
      cycle(0, 8'd0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) cycle(1, 8'd1, 0, 1, 1, 0);
      cycle(0, 8'd0, 0, 1, 1, 0);

      // Backpressure in HOLD while a sample waits
      for (int i = 0; i < 4; i++) cycle(1, 8'd2, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1, 8'd9, 0, 1, 0, 0);
      cycle(1, 8'd9, 0, 1, 1, 0);
      cycle(1, 8'd9, 1, 1, 1, 0);
      chk("t5_model_data", m_data, 9);
      cycle(0, 8'd0, 0, 1, 1, 0);

      // Reset mid-block, en gaps mid-block
      cycle(1, 8'd50, 0, 1, 1, 0);
      cycle(1, 8'd60, 0, 1, 1, 0);
      cycle(0, 8'd0, 0, 1, 1, 1);
      cycle(1, 8'd1, 0, 1, 1, 0);
      cycle(1, 8'd2, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 8'd99, 0, 0, 1, 0);
      cycle(1, 8'd3, 0, 1, 1, 0);
      cycle(1, 8'd4, 0, 1, 1, 0);
      chk("t6_model_data", m_data, 10);
      cycle(0, 8'd0, 0, 1, 1, 0);

      // Randomized traffic, including large values for saturation
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom % 10) < 7, 8'($urandom_range(0, 255)), ($urandom % 8) == 0,
               ($urandom % 8) != 0, ($urandom % 10) < 6, ($urandom % 100) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
      $finish;
   end

endmodule
